// File: rtl/proyecto3_system_stream_packer_if.sv
// Bundles the control, Avalon-ST sink and Avalon-MM write-master signals of the stream packer.
// The "master" modport is the packer side; "slave" is the environment side.
interface proyecto3_system_stream_packer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   max_words;
  logic [7:0]        sink_data;
  logic              sink_valid;
  logic              sink_startofpacket;
  logic              sink_endofpacket;
  logic              sink_ready;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  start, base_addr, max_words,
    input  sink_data, sink_valid, sink_startofpacket, sink_endofpacket,
    output sink_ready,
    output address, byteenable, chipselect, write, writedata, clken,
    output busy, done, overflow, word_count
  );

  modport slave (
    output start, base_addr, max_words,
    output sink_data, sink_valid, sink_startofpacket, sink_endofpacket,
    input  sink_ready,
    input  address, byteenable, chipselect, write, writedata, clken,
    input  busy, done, overflow, word_count
  );
endinterface

// File: rtl/proyecto3_system_stream_packer.sv
// Packs one packet of 8-bit stream beats little-endian into 32-bit words and writes them
// to consecutive memory words from a programmed base; byteenable masks the final partial word.
module proyecto3_system_stream_packer #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic clk,
  input  logic reset,
  proyecto3_system_stream_packer_if.master bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    PACK  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       lanes_q, lanes_d;
  logic [2:0]        lane_cnt_q, lane_cnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic [31:0]       writedata_q, writedata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              sink_ready_q, sink_ready_d;

  logic              accept_c;
  logic [31:0]       lane_byte_c;
  logic [2:0]        lane_inc_c;

  assign accept_c    = bus.sink_valid & sink_ready_q;
  assign lane_byte_c = 32'(bus.sink_data) << {lane_cnt_q[1:0], 3'b000};
  assign lane_inc_c  = lane_cnt_q + 3'(1);

  function automatic logic [3:0] lane_mask(input logic [2:0] cnt);
    case (cnt)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd3:    lane_mask = 4'b0111;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d      = state_q;
    lanes_d      = lanes_q;
    lane_cnt_d   = lane_cnt_q;
    last_d       = last_q;
    base_d       = base_q;
    max_d        = max_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    write_d      = 1'b0;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d       = bus.base_addr;
          max_d        = bus.max_words;
          word_count_d = '0;
          overflow_d   = 1'b0;
          lane_cnt_d   = '0;
          lanes_d      = '0;
          last_d       = 1'b0;
          state_d      = ARMED;
        end
      end

      ARMED: begin
        if (accept_c && bus.sink_startofpacket) begin
          if (max_q == '0) begin
            overflow_d = 1'b1;
            if (bus.sink_endofpacket) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            lanes_d    = 32'(bus.sink_data);
            lane_cnt_d = 3'd1;
            if (bus.sink_endofpacket) begin
              last_d       = 1'b1;
              write_d      = 1'b1;
              address_d    = base_q + word_count_q[ADDR_W-1:0];
              writedata_d  = 32'(bus.sink_data);
              byteenable_d = lane_mask(3'd1);
              state_d      = WRITE;
            end else begin
              state_d = PACK;
            end
          end
        end
      end

      PACK: begin
        if (accept_c) begin
          lanes_d    = lanes_q | lane_byte_c;
          lane_cnt_d = lane_inc_c;
          if (lane_inc_c == 3'd4 || bus.sink_endofpacket) begin
            last_d       = bus.sink_endofpacket;
            write_d      = 1'b1;
            address_d    = base_q + word_count_q[ADDR_W-1:0];
            writedata_d  = lanes_q | lane_byte_c;
            byteenable_d = lane_mask(lane_inc_c);
            state_d      = WRITE;
          end
        end
      end

      WRITE: begin
        word_count_d = word_count_q + CNT_W'(1);
        lane_cnt_d   = '0;
        lanes_d      = '0;
        if (last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (word_count_q + CNT_W'(1) == max_q) begin
          state_d = DRAIN;
        end else begin
          state_d = PACK;
        end
      end

      DRAIN: begin
        if (accept_c) begin
          overflow_d = 1'b1;
          if (bus.sink_endofpacket) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    sink_ready_d = (state_d == ARMED) || (state_d == PACK) || (state_d == DRAIN);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lanes_q      <= '0;
      lane_cnt_q   <= '0;
      last_q       <= 1'b0;
      base_q       <= '0;
      max_q        <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      sink_ready_q <= 1'b0;
    end else begin
      lanes_q      <= lanes_d;
      lane_cnt_q   <= lane_cnt_d;
      last_q       <= last_d;
      base_q       <= base_d;
      max_q        <= max_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      write_q      <= write_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      sink_ready_q <= sink_ready_d;
    end
  end

  assign bus.sink_ready = sink_ready_q;
  assign bus.address    = address_q;
  assign bus.byteenable = byteenable_q;
  assign bus.chipselect = write_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.clken      = 1'b1;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_proyecto3_system_stream_packer.sv
// Scoreboard bench for the stream packer: directed packets push expected writes and
// completions; a negedge monitor pops and compares whenever write or done is presented.
module tb_proyecto3_system_stream_packer;

  localparam int unsigned ADDR_W = 14;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } wr_t;

  typedef struct packed {
    logic [ADDR_W:0] wc;
    logic            ovf;
    logic            adj;
  } dn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  proyecto3_system_stream_packer_if #(.ADDR_W(ADDR_W)) bus ();

  proyecto3_system_stream_packer #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = -10;
  int done_cnt = 0;
  wr_t wr_q[$];
  dn_t dn_q[$];
  logic [7:0] pkt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every presented write and done against the scoreboard queues
  always @(negedge clk) begin
    if (!reset && bus.write) begin
      wr_t e;
      check("write_cs", 64'(bus.chipselect), 64'd1);
      check("write_sink_ready", 64'(bus.sink_ready), 64'd0);
      if (wr_q.size() == 0) begin
        check("unexpected_write", 64'(bus.address), 64'hFFFF_FFFF);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", 64'(bus.address), 64'(e.addr));
        check("wr_be", 64'(bus.byteenable), 64'(e.be));
        check("wr_data", 64'(bus.writedata), 64'(e.data));
      end
      last_wr_cyc = cyc;
    end
    if (!reset && bus.done) begin
      dn_t d;
      done_cnt++;
      check("done_busy", 64'(bus.busy), 64'd0);
      if (dn_q.size() == 0) begin
        check("unexpected_done", 64'(bus.word_count), 64'hFFFF_FFFF);
      end else begin
        d = dn_q.pop_front();
        check("done_word_count", 64'(bus.word_count), 64'(d.wc));
        check("done_overflow", 64'(bus.overflow), 64'(d.ovf));
        if (d.adj) check("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
      end
    end
  end

  task automatic arm(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] maxw);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.max_words = maxw;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Presents one beat from a negedge and returns at the negedge after it is accepted
  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
    int n = 0;
    bus.sink_valid         = 1'b1;
    bus.sink_data          = d;
    bus.sink_startofpacket = sop;
    bus.sink_endofpacket   = eop;
    while (!bus.sink_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("beat_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic send_packet(input int gaps, input int start_idx);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps != 0 && (i % 3) == 1) begin
        bus.sink_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      bus.start     = (i == start_idx);
      bus.base_addr = 14'h2222;
      bus.max_words = 15'd3;
      send_beat(pkt[i], i == 0, i == pkt.size() - 1);
      bus.start = 1'b0;
    end
    bus.sink_valid         = 1'b0;
    bus.sink_startofpacket = 1'b0;
    bus.sink_endofpacket   = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 64'(done_cnt >= target), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic load8();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  initial begin
    int target;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.max_words = '0;
    bus.sink_data = '0;
    bus.sink_valid = 1'b0;
    bus.sink_startofpacket = 1'b0;
    bus.sink_endofpacket = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sink_ready", 64'(bus.sink_ready), 64'd0);
    check("rst_write", 64'(bus.write), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_address", 64'(bus.address), 64'd0);
    check("rst_writedata", 64'(bus.writedata), 64'd0);
    check("rst_word_count", 64'(bus.word_count), 64'd0);
    check("rst_clken", 64'(bus.clken), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    target = 0;

    // Full words
    wr_q.push_back('{14'h0100, 4'hF, 32'h44332211});
    wr_q.push_back('{14'h0101, 4'hF, 32'h88776655});
    dn_q.push_back('{15'd2, 1'b0, 1'b1});
    arm(14'h0100, 15'd8);
    check("armed_busy", 64'(bus.busy), 64'd1);
    check("armed_sink_ready", 64'(bus.sink_ready), 64'd1);
    load8();
    send_packet(0, -1);
    target++; wait_done(target);

    // Partial tail
    wr_q.push_back('{14'h0200, 4'hF, 32'h44332211});
    wr_q.push_back('{14'h0201, 4'h3, 32'h00006655});
    dn_q.push_back('{15'd2, 1'b0, 1'b1});
    arm(14'h0200, 15'd8);
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_packet(0, -1);
    target++; wait_done(target);

    // Single sop+eop beat
    wr_q.push_back('{14'h0010, 4'h1, 32'h000000A5});
    dn_q.push_back('{15'd1, 1'b0, 1'b1});
    arm(14'h0010, 15'd8);
    pkt = '{8'hA5};
    send_packet(0, -1);
    target++; wait_done(target);

    // Address wrap
    wr_q.push_back('{14'h3FFF, 4'hF, 32'h44332211});
    wr_q.push_back('{14'h0000, 4'hF, 32'h88776655});
    dn_q.push_back('{15'd2, 1'b0, 1'b1});
    arm(14'h3FFF, 15'd8);
    load8();
    send_packet(0, -1);
    target++; wait_done(target);

    // Budget overflow: one word then drain to eop
    wr_q.push_back('{14'h0040, 4'hF, 32'h44332211});
    dn_q.push_back('{15'd1, 1'b1, 1'b0});
    arm(14'h0040, 15'd1);
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_packet(0, -1);
    target++; wait_done(target);

    // Zero budget: sop+eop beat only flags overflow
    dn_q.push_back('{15'd0, 1'b1, 1'b0});
    arm(14'h0050, 15'd0);
    pkt = '{8'h5A};
    send_packet(0, -1);
    target++; wait_done(target);

    // Beats without sop in ARMED are dropped; start while busy is ignored
    wr_q.push_back('{14'h0300, 4'hF, 32'hDDCCBBAA});
    dn_q.push_back('{15'd1, 1'b0, 1'b1});
    arm(14'h0300, 15'd8);
    send_beat(8'hEE, 1'b0, 1'b0);
    send_beat(8'hEF, 1'b0, 1'b1);
    bus.sink_valid = 1'b0;
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_packet(0, 2);
    target++; wait_done(target);

    // Valid gaps give the same writes as the continuous case
    wr_q.push_back('{14'h0100, 4'hF, 32'h44332211});
    wr_q.push_back('{14'h0101, 4'hF, 32'h88776655});
    dn_q.push_back('{15'd2, 1'b0, 1'b1});
    arm(14'h0100, 15'd8);
    load8();
    send_packet(1, -1);
    target++; wait_done(target);

    // Reset mid-packet loses the partial word
    arm(14'h0700, 15'd8);
    send_beat(8'h11, 1'b1, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b0, 1'b0);
    bus.sink_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_write", 64'(bus.write), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_sink_ready", 64'(bus.sink_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr_q.push_back('{14'h0100, 4'hF, 32'h44332211});
    wr_q.push_back('{14'h0101, 4'hF, 32'h88776655});
    dn_q.push_back('{15'd2, 1'b0, 1'b1});
    arm(14'h0100, 15'd8);
    load8();
    send_packet(0, -1);
    target++; wait_done(target);

    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("done_queue_empty", 64'(dn_q.size()), 64'd0);
    check("final_idle_busy", 64'(bus.busy), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
